// File: rtl/cnn_pkg.sv
// Shared types and sizing helpers for the convolution tile scheduler.
package cnn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    SCAN,
    DRAIN,
    DONE
  } sched_state_t;

  localparam int PERF_W = 32;
  localparam int MIN_W  = 1;

  function automatic int out_dim(int img, int k, int s);
    return (img - k) / s + 1;
  endfunction

  // Coordinate width; a 1-entry range still needs one bit.
  function automatic int cw(int n);
    return (n > 1) ? $clog2(n) : MIN_W;
  endfunction

endpackage

// File: rtl/sched_delay_line.sv
// PE_LATENCY-deep valid/coordinate/last pipeline with a common hold.
module sched_delay_line
  import cnn_pkg::*;
#(
  parameter int LAT = 1,
  parameter int RW  = 1,
  parameter int CW  = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          hold,
  input  logic          in_valid,
  input  logic [RW-1:0] in_row,
  input  logic [CW-1:0] in_col,
  input  logic          in_last,
  output logic          out_valid,
  output logic [RW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic          out_last
);

  logic [LAT-1:0] v_q;
  logic [LAT-1:0] l_q;
  logic [RW-1:0]  r_q [LAT];
  logic [CW-1:0]  c_q [LAT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q <= '0;
      l_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        r_q[i] <= '0;
        c_q[i] <= '0;
      end
    end else if (!hold) begin
      v_q[0] <= in_valid;
      l_q[0] <= in_last;
      r_q[0] <= in_row;
      c_q[0] <= in_col;
      for (int i = 1; i < LAT; i++) begin
        v_q[i] <= v_q[i-1];
        l_q[i] <= l_q[i-1];
        r_q[i] <= r_q[i-1];
        c_q[i] <= c_q[i-1];
      end
    end
  end

  assign out_valid = v_q[LAT-1];
  assign out_last  = l_q[LAT-1];
  assign out_row   = r_q[LAT-1];
  assign out_col   = c_q[LAT-1];

endmodule

// File: rtl/conv_tile_scheduler.sv
// Weight load + raster tile sequencer for the conv PE array.
// Optional perf counters: define CNN_SCHED_PERF_EN.
module conv_tile_scheduler
  import cnn_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 28,
  parameter int IMAGE_HEIGHT = 28,
  parameter int NUM_FEATURES = 10,
  parameter int KERNEL_SIZE  = 3,
  parameter int STRIDE       = 1,
  parameter int PE_LATENCY   = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  output logic wt_rd_en,
  output logic [cw(NUM_FEATURES)-1:0] wt_rd_addr,
  output logic col_wr_en,
  output logic [cw(NUM_FEATURES)-1:0] col_wr_sel,
  output logic pe_en,
  output logic tile_valid,
  output logic [cw(IMAGE_HEIGHT)-1:0] tile_row,
  output logic [cw(IMAGE_WIDTH)-1:0] tile_col,
  output logic out_valid,
  input  logic out_ready,
  output logic [cw(out_dim(IMAGE_HEIGHT, KERNEL_SIZE, STRIDE))-1:0] out_row,
  output logic [cw(out_dim(IMAGE_WIDTH, KERNEL_SIZE, STRIDE))-1:0] out_col,
  output logic out_last
`ifdef CNN_SCHED_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_cycles,
  output logic [PERF_W-1:0] perf_stalls
`endif
);

  localparam int OUT_W = out_dim(IMAGE_WIDTH, KERNEL_SIZE, STRIDE);
  localparam int OUT_H = out_dim(IMAGE_HEIGHT, KERNEL_SIZE, STRIDE);
  localparam int FW  = cw(NUM_FEATURES);
  localparam int LW  = cw(NUM_FEATURES + 1);
  localparam int TRW = cw(IMAGE_HEIGHT);
  localparam int TCW = cw(IMAGE_WIDTH);
  localparam int ORW = cw(OUT_H);
  localparam int OCW = cw(OUT_W);

  sched_state_t state_q, state_d;

  logic [LW-1:0]  ld_cnt;
  logic [ORW-1:0] scan_row;
  logic [OCW-1:0] scan_col;
  logic [TRW-1:0] acc_row;
  logic [TCW-1:0] acc_col;

  logic ld_last;
  logic stall;
  logic issue;
  logic row_end;
  logic tile_last;
  logic out_hs_last;

  assign ld_last   = (ld_cnt == LW'(NUM_FEATURES));
  assign stall     = out_valid && !out_ready;
  assign issue     = (state_q == SCAN) && !stall;
  assign row_end   = (scan_col == OCW'(OUT_W - 1));
  assign tile_last = row_end && (scan_row == ORW'(OUT_H - 1));
  assign out_hs_last = out_valid && out_ready && out_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LOAD_W;
      LOAD_W:  if (ld_last) state_d = SCAN;
      SCAN:    if (issue && tile_last) state_d = DRAIN;
      DRAIN:   if (out_hs_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  ld_cnt <= '0;
    else if (state_q == LOAD_W) ld_cnt <= ld_cnt + LW'(1);
    else                        ld_cnt <= '0;
  end

  // Running adders track tile origin alongside the output coordinate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_row <= '0;
      scan_col <= '0;
      acc_row  <= '0;
      acc_col  <= '0;
    end else if (state_q == LOAD_W) begin
      scan_row <= '0;
      scan_col <= '0;
      acc_row  <= '0;
      acc_col  <= '0;
    end else if (issue) begin
      if (row_end) begin
        scan_col <= '0;
        acc_col  <= '0;
        scan_row <= scan_row + ORW'(1);
        acc_row  <= acc_row + TRW'(STRIDE);
      end else begin
        scan_col <= scan_col + OCW'(1);
        acc_col  <= acc_col + TCW'(STRIDE);
      end
    end
  end

  always_comb begin
    busy       = (state_q == LOAD_W) || (state_q == SCAN) ||
                 (state_q == DRAIN);
    done       = (state_q == DONE);
    wt_rd_en   = (state_q == LOAD_W) && !ld_last;
    wt_rd_addr = wt_rd_en ? FW'(ld_cnt) : '0;
    col_wr_en  = (state_q == LOAD_W) && (ld_cnt != '0);
    col_wr_sel = col_wr_en ? FW'(ld_cnt - LW'(1)) : '0;
    pe_en      = ((state_q == SCAN) || (state_q == DRAIN)) && !stall;
    tile_valid = issue;
    tile_row   = issue ? acc_row : '0;
    tile_col   = issue ? acc_col : '0;
  end

  sched_delay_line #(
    .LAT (PE_LATENCY),
    .RW  (ORW),
    .CW  (OCW)
  ) u_dly (
    .clk       (clk),
    .reset     (reset),
    .hold      (stall),
    .in_valid  (issue),
    .in_row    (issue ? scan_row : '0),
    .in_col    (issue ? scan_col : '0),
    .in_last   (issue && tile_last),
    .out_valid (out_valid),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last)
  );

`ifdef CNN_SCHED_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (state_q == IDLE && start) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else begin
      if (busy && !(&perf_cycles))  perf_cycles <= perf_cycles + 1'b1;
      if (stall && !(&perf_stalls)) perf_stalls <= perf_stalls + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Directed bench: 5x5 S1 instance (a) and 6x6 S2 instance (b).
module tb_conv_tile_scheduler;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic start_b = 1'b0;
  logic out_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  logic       a_busy, a_done, a_rd, a_wr, a_pe, a_tv, a_ov, a_last;
  logic [3:0] a_ra, a_ws;
  logic [2:0] a_tr, a_tc;
  logic [1:0] a_or, a_oc;

  logic       b_busy, b_done, b_rd, b_wr, b_pe, b_tv, b_ov, b_last;
  logic [3:0] b_ra, b_ws;
  logic [2:0] b_tr, b_tc;
  logic       b_or, b_oc;

`ifdef CNN_SCHED_PERF_EN
  logic [31:0] a_pc, a_ps, b_pc, b_ps;
`endif

  always #5 clk = ~clk;

  conv_tile_scheduler #(
    .IMAGE_WIDTH(5), .IMAGE_HEIGHT(5), .NUM_FEATURES(10),
    .KERNEL_SIZE(3), .STRIDE(1), .PE_LATENCY(1)
  ) u_a (
    .clk(clk), .reset(reset), .start(start),
    .busy(a_busy), .done(a_done),
    .wt_rd_en(a_rd), .wt_rd_addr(a_ra),
    .col_wr_en(a_wr), .col_wr_sel(a_ws),
    .pe_en(a_pe), .tile_valid(a_tv),
    .tile_row(a_tr), .tile_col(a_tc),
    .out_valid(a_ov), .out_ready(out_ready),
    .out_row(a_or), .out_col(a_oc), .out_last(a_last)
`ifdef CNN_SCHED_PERF_EN
    , .perf_cycles(a_pc), .perf_stalls(a_ps)
`endif
  );

  conv_tile_scheduler #(
    .IMAGE_WIDTH(6), .IMAGE_HEIGHT(6), .NUM_FEATURES(10),
    .KERNEL_SIZE(3), .STRIDE(2), .PE_LATENCY(1)
  ) u_b (
    .clk(clk), .reset(reset), .start(start_b),
    .busy(b_busy), .done(b_done),
    .wt_rd_en(b_rd), .wt_rd_addr(b_ra),
    .col_wr_en(b_wr), .col_wr_sel(b_ws),
    .pe_en(b_pe), .tile_valid(b_tv),
    .tile_row(b_tr), .tile_col(b_tc),
    .out_valid(b_ov), .out_ready(1'b1),
    .out_row(b_or), .out_col(b_oc), .out_last(b_last)
`ifdef CNN_SCHED_PERF_EN
    , .perf_cycles(b_pc), .perf_stalls(b_ps)
`endif
  );

  wire [25:0] act_a = {a_busy, a_done, a_rd, a_ra, a_wr, a_ws, a_pe,
                       a_tv, a_tr, a_tc, a_ov, a_or, a_oc, a_last};
  wire [11:0] act_b = {b_tv, b_tr, b_tc, b_ov, b_or, b_oc, b_last, b_done};

  // Expected 5x5 outputs at cycle c (start at 0), sl stalls from cycle 13.
  function automatic logic [25:0] exp_a(int c, int sl);
    logic bs, dn, rd, wr, pe, tv, ov, la;
    logic [3:0] ra, ws;
    logic [2:0] tr, tc;
    logic [1:0] orw, oc;
    int k;
    bs = 0; dn = 0; rd = 0; wr = 0; pe = 0; tv = 0; ov = 0; la = 0;
    ra = 0; ws = 0; tr = 0; tc = 0; orw = 0; oc = 0;
    bs = (c >= 1) && (c <= 21 + sl);
    dn = (c == 22 + sl);
    if (c >= 1 && c <= 10) begin rd = 1; ra = 4'(c - 1); end
    if (c >= 2 && c <= 11) begin wr = 1; ws = 4'(c - 2); end
    pe = (c == 12) || (c >= 13 + sl && c <= 21 + sl);
    k = -1;
    if (c == 12) k = 0;
    else if (c >= 13 + sl && c <= 20 + sl) k = c - 12 - sl;
    if (k >= 0) begin tv = 1; tr = 3'(k / 3); tc = 3'(k % 3); end
    if (c >= 13 && c <= 21 + sl) begin
      ov = 1;
      k = (c <= 13 + sl) ? 0 : c - 13 - sl;
      orw = 2'(k / 3);
      oc = 2'(k % 3);
      la = (c == 21 + sl);
    end
    return {bs, dn, rd, ra, wr, ws, pe, tv, tr, tc, ov, orw, oc, la};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (act_a !== 26'd0) begin
      errors++;
      $display("FAIL reset_a got %h want 0", act_a);
    end
    checks++;
    if (act_b !== 12'd0 || b_busy !== 1'b0 || b_pe !== 1'b0) begin
      errors++;
      $display("FAIL reset_b got %h want 0", act_b);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    for (int c = 0; c <= 23; c++) begin
      if (c > 0) @(negedge clk);
      start = (c == 0);
      #1;
      checks++;
      if (act_a !== exp_a(c, 0)) begin
        errors++;
        $display("FAIL nominal c=%0d got %h want %h", c, act_a, exp_a(c, 0));
      end
    end
    start = 1'b0;
  endtask

  task automatic test_stride2();
    logic [11:0] e;
    int k;
    for (int c = 0; c <= 18; c++) begin
      if (c > 0) @(negedge clk);
      start_b = (c == 0);
      #1;
      e = '0;
      if (c >= 12 && c <= 15) begin
        k = c - 12;
        e[11] = 1'b1;
        e[10:8] = 3'((k / 2) * 2);
        e[7:5] = 3'((k % 2) * 2);
      end
      if (c >= 13 && c <= 16) begin
        k = c - 13;
        e[4] = 1'b1;
        e[3] = 1'(k / 2);
        e[2] = 1'(k % 2);
        e[1] = (c == 16);
      end
      e[0] = (c == 17);
      if (c >= 10) begin
        checks++;
        if (act_b !== e) begin
          errors++;
          $display("FAIL stride2 c=%0d got %h want %h", c, act_b, e);
        end
      end
    end
    start_b = 1'b0;
  endtask

  task automatic test_stall();
    for (int c = 0; c <= 26; c++) begin
      if (c > 0) @(negedge clk);
      start = (c == 0);
      out_ready = !(c >= 13 && c <= 15);
      #1;
      checks++;
      if (act_a !== exp_a(c, 3)) begin
        errors++;
        $display("FAIL stall c=%0d got %h want %h", c, act_a, exp_a(c, 3));
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_start_ignored();
    for (int c = 0; c <= 24; c++) begin
      if (c > 0) @(negedge clk);
      start = (c == 0) || (c == 5) || (c == 22);
      #1;
      checks++;
      if (act_a !== exp_a(c, 0)) begin
        errors++;
        $display("FAIL start_ign c=%0d got %h want %h", c, act_a, exp_a(c, 0));
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c <= 15; c++) begin
      if (c > 0) @(negedge clk);
      start = (c == 0);
      #1;
      checks++;
      if (act_a !== exp_a(c, 0)) begin
        errors++;
        $display("FAIL rst_pre c=%0d got %h want %h", c, act_a, exp_a(c, 0));
      end
    end
    start = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (act_a !== 26'd0) begin
      errors++;
      $display("FAIL rst_async got %h want 0", act_a);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (a_done !== 1'b0 || a_busy !== 1'b0) begin
        errors++;
        $display("FAIL rst_idle c=%0d done=%b busy=%b want 0 0",
                 c, a_done, a_busy);
      end
    end
    for (int c = 0; c <= 23; c++) begin
      @(negedge clk);
      start = (c == 0);
      #1;
      checks++;
      if (act_a !== exp_a(c, 0)) begin
        errors++;
        $display("FAIL rst_replay c=%0d got %h want %h", c, act_a, exp_a(c, 0));
      end
    end
    start = 1'b0;
  endtask

`ifdef CNN_SCHED_PERF_EN
  task automatic test_perf();
    for (int c = 0; c <= 26; c++) begin
      if (c > 0) @(negedge clk);
      start = (c == 0);
      out_ready = !(c >= 13 && c <= 15);
      #1;
      if (c == 1) begin
        checks++;
        if (a_pc !== 32'd0 || a_ps !== 32'd0) begin
          errors++;
          $display("FAIL perf_clear got %0d %0d want 0 0", a_pc, a_ps);
        end
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (a_pc !== 32'd24) begin
      errors++;
      $display("FAIL perf_cycles got %0d want 24", a_pc);
    end
    checks++;
    if (a_ps !== 32'd3) begin
      errors++;
      $display("FAIL perf_stalls got %0d want 3", a_ps);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_stride2();
    test_stall();
    test_start_ignored();
    @(negedge clk);
    test_reset_mid();
`ifdef CNN_SCHED_PERF_EN
    @(negedge clk);
    test_perf();
`endif
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
